// File: rtl/stdp_pkg.sv
// Shared constants and helpers for the multi-channel STDP engine.
// Decay and clamp helpers work on 32-bit ints. Callers narrow the results to their own widths.
package stdp_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_TW      = 8;
  localparam int DEF_WW      = 8;
  localparam int DEF_W_INIT  = 16;
  localparam int DEF_W_MIN   = 0;
  localparam int DEF_W_MAX   = 255;
  localparam int DEF_A_PLUS  = 8;
  localparam int DEF_A_MINUS = 4;
  localparam int DEF_TAU_SH  = 2;
  localparam int DEF_WINDOW  = 32;

  // The amplitude halves once per 2^tau_sh cycles of elapsed time.
  // A shift amount at or beyond the word width yields zero.
  function automatic int unsigned stdp_delta(input int unsigned amp,
                                             input int unsigned dt,
                                             input int unsigned tau_sh);
    int unsigned sh;
    sh = dt >> tau_sh;
    if (sh >= 32) begin
      return 0;
    end
    return amp >> sh;
  endfunction

  function automatic int sat_hi(input int v, input int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic int sat_lo(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One presynaptic channel: its spike timer, its weight, and the LTP/LTD decision
// against the shared postsynaptic timer.
module stdp_synapse
  import stdp_pkg::*;
#(
  parameter int TW      = DEF_TW,
  parameter int WW      = DEF_WW,
  parameter int W_INIT  = DEF_W_INIT,
  parameter int W_MIN   = DEF_W_MIN,
  parameter int W_MAX   = DEF_W_MAX,
  parameter int A_PLUS  = DEF_A_PLUS,
  parameter int A_MINUS = DEF_A_MINUS,
  parameter int TAU_SH  = DEF_TAU_SH,
  parameter int WINDOW  = DEF_WINDOW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          learn_en,
  input  logic          pre_spike,
  input  logic          post_spike,
  input  logic [TW-1:0] post_t,
  output logic [WW-1:0] weight,
  output logic          ltp_pulse,
  output logic          ltd_pulse
);

  localparam logic [TW-1:0] T_SAT = '1;

  logic [TW-1:0]        pre_t;
  logic [WW-1:0]        ltp_delta;
  logic [WW-1:0]        ltd_delta;
  logic                 ltp_fire;
  logic                 ltd_fire;
  logic [WW:0]          sum_wide;
  logic signed [WW:0]   diff_wide;
  logic [WW-1:0]        weight_next;

  // The timer sticks at all-ones, so a stale pre spike can never re-enter the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_t <= T_SAT;
    end else if (pre_spike) begin
      pre_t <= '0;
    end else if (pre_t != T_SAT) begin
      pre_t <= pre_t + 1'b1;
    end
  end

  always_comb begin
    ltp_delta = '0;
    ltd_delta = '0;
    if (32'(pre_t) < WINDOW) begin
      ltp_delta = WW'(stdp_delta(A_PLUS, 32'(pre_t), TAU_SH));
    end
    if (32'(post_t) < WINDOW) begin
      ltd_delta = WW'(stdp_delta(A_MINUS, 32'(post_t), TAU_SH));
    end
  end

  // Coincident pre and post cancel each other. A zero delta is not treated as an update.
  assign ltp_fire = post_spike && !pre_spike && (ltp_delta != '0);
  assign ltd_fire = pre_spike && !post_spike && (ltd_delta != '0);

  assign sum_wide  = {1'b0, weight} + {1'b0, ltp_delta};
  assign diff_wide = $signed({1'b0, weight}) - $signed({1'b0, ltd_delta});

  always_comb begin
    weight_next = weight;
    if (learn_en && ltp_fire) begin
      weight_next = WW'(sat_hi(int'(sum_wide), W_MAX));
    end else if (learn_en && ltd_fire) begin
      weight_next = WW'(sat_lo(int'(diff_wide), W_MIN));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight    <= WW'(W_INIT);
      ltp_pulse <= 1'b0;
      ltd_pulse <= 1'b0;
    end else begin
      weight    <= weight_next;
      ltp_pulse <= learn_en && ltp_fire;
      ltd_pulse <= learn_en && ltd_fire;
    end
  end

endmodule

// File: rtl/stdp_array.sv
// Multi-channel STDP engine. One synapse per presynaptic channel shares a single
// postsynaptic timer. The top level also provides the registered readout and the flat weight bus.
module stdp_array
  import stdp_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int TW      = DEF_TW,
  parameter int WW      = DEF_WW,
  parameter int W_INIT  = DEF_W_INIT,
  parameter int W_MIN   = DEF_W_MIN,
  parameter int W_MAX   = DEF_W_MAX,
  parameter int A_PLUS  = DEF_A_PLUS,
  parameter int A_MINUS = DEF_A_MINUS,
  parameter int TAU_SH  = DEF_TAU_SH,
  parameter int WINDOW  = DEF_WINDOW
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    learn_en,
  input  logic [N_CH-1:0]                         pre_spike,
  input  logic                                    post_spike,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] rd_addr,
  output logic [WW-1:0]                           weight_o,
  output logic [N_CH*WW-1:0]                      weights,
  output logic [N_CH-1:0]                         ltp_pulse,
  output logic [N_CH-1:0]                         ltd_pulse
);

  localparam logic [TW-1:0] T_SAT = '1;

  logic [TW-1:0] post_t;
  logic [WW-1:0] w_arr [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_t <= T_SAT;
    end else if (post_spike) begin
      post_t <= '0;
    end else if (post_t != T_SAT) begin
      post_t <= post_t + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      stdp_synapse #(
        .TW      (TW),
        .WW      (WW),
        .W_INIT  (W_INIT),
        .W_MIN   (W_MIN),
        .W_MAX   (W_MAX),
        .A_PLUS  (A_PLUS),
        .A_MINUS (A_MINUS),
        .TAU_SH  (TAU_SH),
        .WINDOW  (WINDOW)
      ) u_syn (
        .clk        (clk),
        .rst        (rst),
        .learn_en   (learn_en),
        .pre_spike  (pre_spike[gi]),
        .post_spike (post_spike),
        .post_t     (post_t),
        .weight     (w_arr[gi]),
        .ltp_pulse  (ltp_pulse[gi]),
        .ltd_pulse  (ltd_pulse[gi])
      );
      assign weights[gi*WW +: WW] = w_arr[gi];
    end
  endgenerate

  // The readout lags the weight bus by one cycle. Unpopulated addresses read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_o <= '0;
    end else if (32'(rd_addr) < N_CH) begin
      weight_o <= w_arr[rd_addr];
    end else begin
      weight_o <= '0;
    end
  end

endmodule

// File: tb/tb_stdp_array.sv
// Scoreboard bench for stdp_array: a behavioural model queues the expected bus state per edge,
// which is popped and compared after the edge; scenario checkpoints add fixed expectations.
module tb_stdp_array;

  logic        clk;
  logic        rst;
  logic        learn_en;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic [1:0]  rd_addr;
  logic [7:0]  weight_o;
  logic [31:0] weights;
  logic [3:0]  ltp_pulse;
  logic [3:0]  ltd_pulse;

  stdp_array dut (
    .clk        (clk),
    .rst        (rst),
    .learn_en   (learn_en),
    .pre_spike  (pre_spike),
    .post_spike (post_spike),
    .rd_addr    (rd_addr),
    .weight_o   (weight_o),
    .weights    (weights),
    .ltp_pulse  (ltp_pulse),
    .ltd_pulse  (ltd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  ltp;
    logic [3:0]  ltd;
    logic [7:0]  wo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_pre_t [4];
  int   m_post_t;
  int   m_w [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pre_t[i] = 255;
      m_w[i]     = 16;
    end
    m_post_t = 255;
  endtask

  // Drive one cycle, queue the model's view of the following edge, then compare.
  task automatic step(input logic [3:0] pre, input logic post, input logic learn);
    exp_t       e;
    exp_t       got;
    int         d;
    logic [1:0] addr;
    addr  = 2'(cyc % 4);
    e.wo  = 8'(m_w[addr]);
    e.ltp = '0;
    e.ltd = '0;
    for (int i = 0; i < 4; i++) begin
      if (post && !pre[i] && m_pre_t[i] < 32) begin
        d = 8 >> (m_pre_t[i] / 4);
        if (d > 0 && learn) begin
          m_w[i]   = (m_w[i] + d > 255) ? 255 : m_w[i] + d;
          e.ltp[i] = 1'b1;
        end
      end
      if (pre[i] && !post && m_post_t < 32) begin
        d = 4 >> (m_post_t / 4);
        if (d > 0 && learn) begin
          m_w[i]   = (m_w[i] - d < 0) ? 0 : m_w[i] - d;
          e.ltd[i] = 1'b1;
        end
      end
      m_pre_t[i] = pre[i] ? 0 : ((m_pre_t[i] < 255) ? m_pre_t[i] + 1 : 255);
      e.w[i*8 +: 8] = 8'(m_w[i]);
    end
    m_post_t = post ? 0 : ((m_post_t < 255) ? m_post_t + 1 : 255);
    sb.push_back(e);
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    rd_addr    = addr;
    @(posedge clk);
    #1;
    cyc++;
    got = sb.pop_front();
    check_val("weights",   weights,            got.w);
    check_val("ltp_pulse", 32'(ltp_pulse),     32'(got.ltp));
    check_val("ltd_pulse", 32'(ltd_pulse),     32'(got.ltd));
    check_val("weight_o",  32'(weight_o),      32'(got.wo));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'b0000, 1'b0, 1'b1);
  endtask

  // Reset is asserted between clock edges; its effect must be visible before the next edge.
  task automatic async_reset();
    pre_spike  = '0;
    post_spike = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_weights", weights,          32'h10101010);
    check_val("rst_ltp",     32'(ltp_pulse),   32'h0);
    check_val("rst_ltd",     32'(ltd_pulse),   32'h0);
    check_val("rst_wo",      32'(weight_o),    32'h0);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst        = 1'b1;
    learn_en   = 1'b1;
    pre_spike  = '0;
    post_spike = 1'b0;
    rd_addr    = '0;
    model_reset();
    #3;
    check_val("init_weights", weights,        32'h10101010);
    check_val("init_ltp",     32'(ltp_pulse), 32'h0);
    check_val("init_ltd",     32'(ltd_pulse), 32'h0);
    check_val("init_wo",      32'(weight_o),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // A post spike with no earlier pre spike must not change anything.
    idle(2);
    step(4'b0000, 1'b1, 1'b1);
    check_val("post_only", weights, 32'h10101010);
    idle(40);

    // LTP with dt=2 on channel 0.
    step(4'b0001, 1'b0, 1'b1);
    idle(2);
    step(4'b0000, 1'b1, 1'b1);
    check_val("ltp_w0",    weights,        32'h10101018);
    check_val("ltp_pulse0", 32'(ltp_pulse), 32'h1);
    idle(1);
    check_val("ltp_pulse_gone", 32'(ltp_pulse), 32'h0);
    idle(40);

    // LTD with dt=4 on channel 1.
    step(4'b0000, 1'b1, 1'b1);
    idle(4);
    step(4'b0010, 1'b0, 1'b1);
    check_val("ltd_w1",     32'(weights[15:8]), 32'd14);
    check_val("ltd_pulse1", 32'(ltd_pulse),     32'h2);
    idle(40);

    // Window edge: dt=31 decays to zero, dt=40 is outside the window.
    step(4'b0100, 1'b0, 1'b1);
    idle(31);
    step(4'b0000, 1'b1, 1'b1);
    check_val("win31_w2",  32'(weights[23:16]), 32'd16);
    check_val("win31_ltp", 32'(ltp_pulse),      32'h0);
    idle(40);
    step(4'b0100, 1'b0, 1'b1);
    idle(40);
    step(4'b0000, 1'b1, 1'b1);
    check_val("win40_w2", 32'(weights[23:16]), 32'd16);
    idle(40);

    // Repeated dt=0 LTP pairs on channel 3 saturate at 255, with the pulse still firing.
    for (int p = 0; p < 32; p++) begin
      step(4'b1000, 1'b0, 1'b1);
      step(4'b0000, 1'b1, 1'b1);
      idle(36);
    end
    check_val("sat_w3", 32'(weights[31:24]), 32'd255);

    // Repeated LTD pairs on channel 1 clamp at 0.
    for (int p = 0; p < 6; p++) begin
      step(4'b0000, 1'b1, 1'b1);
      step(4'b0010, 1'b0, 1'b1);
      if (p == 5) begin
        check_val("floor_pulse", 32'(ltd_pulse), 32'h2);
      end
      idle(36);
    end
    check_val("floor_w1", 32'(weights[15:8]), 32'd0);

    // Coincident pre and post spikes on channel 0: no update, but both timers reload.
    step(4'b0001, 1'b1, 1'b1);
    check_val("simul_w0",  32'(weights[7:0]), 32'd24);
    check_val("simul_ltp", 32'(ltp_pulse),    32'h0);
    idle(1);
    step(4'b0000, 1'b1, 1'b1);
    check_val("simul_after_w0", 32'(weights[7:0]), 32'd32);
    idle(40);

    // learn_en low freezes the weights while the timers keep running.
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    check_val("frozen_w2",  32'(weights[23:16]), 32'd16);
    check_val("frozen_ltp", 32'(ltp_pulse),      32'h0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    check_val("reen_w2", 32'(weights[23:16]), 32'd24);
    idle(40);

    // Assert reset while an LTP pulse is active.
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0000, 1'b1, 1'b1);
    check_val("pre_rst_pulse", 32'(ltp_pulse), 32'h2);
    async_reset();
    idle(1);
    step(4'b0000, 1'b1, 1'b1);
    check_val("post_rst_nochg", weights, 32'h10101010);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
